// File: rtl/bist_pkg.sv
// Shared constants for the logic-BIST engine: session states,
// counter width and default feedback masks.
package bist_pkg;

  localparam int CNT_W = 16;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_INIT  = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_FLUSH = 3'd3;
  localparam logic [2:0] ST_CMP   = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  localparam logic [7:0] DEF_LFSR_TAPS = 8'hB8;
  localparam logic [7:0] DEF_MISR_TAPS = 8'hB8;

  typedef enum logic {
    MODE_LFSR,
    MODE_MISR
  } sr_mode_e;

endpackage

// File: rtl/bist_shift_reg.sv
// Fibonacci shift register used both as pattern LFSR and as
// response-compacting MISR (MISR mode folds xor_in into each step).
module bist_shift_reg
  import bist_pkg::*;
#(
  parameter int              WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(DEF_LFSR_TAPS),
  parameter sr_mode_e        MODE  = MODE_LFSR
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             enable,
  input  logic [WIDTH-1:0] xor_in,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] inj;
  logic [WIDTH-1:0] nxt;

  assign inj = (MODE == MODE_MISR) ? xor_in : '0;
  assign nxt = {q[WIDTH-2:0], ^(q & TAPS)} ^ inj;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (enable) begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/bist_engine.sv
// Self-running logic-BIST session: LFSR stimulus, latency-aligned
// MISR compaction and a golden-signature compare.
module bist_engine
  import bist_pkg::*;
#(
  parameter int               WIDTH        = 8,
  parameter int               NUM_PATTERNS = 255,
  parameter int               CUT_LATENCY  = 1,
  parameter logic [WIDTH-1:0] LFSR_TAPS    = WIDTH'(DEF_LFSR_TAPS),
  parameter logic [WIDTH-1:0] MISR_TAPS    = WIDTH'(DEF_MISR_TAPS),
  parameter logic [WIDTH-1:0] LFSR_SEED    = WIDTH'(1),
  parameter logic [WIDTH-1:0] GOLDEN_SIG   = '0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             bist_start,
  input  logic             bist_abort,
  output logic [WIDTH-1:0] cut_stim,
  input  logic [WIDTH-1:0] cut_resp,
  output logic             bist_busy,
  output logic             bist_done,
  output logic             bist_pass,
  output logic [CNT_W-1:0] pattern_count,
  output logic [WIDTH-1:0] signature
);

  localparam logic [WIDTH-1:0] SEED =
    (LFSR_SEED == '0) ? WIDTH'(1) : LFSR_SEED;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_PATTERNS - 1);
  localparam logic [3:0]       FL_LAST = 4'(CUT_LATENCY - 1);

  logic [2:0] st;
  logic [2:0] st_nxt;
  logic [3:0] fl_cnt;
  logic       last;
  logic       init;
  logic       vin;
  logic       cap;
  logic       lfsr_en;
  logic       misr_en;

  assign last    = (pattern_count == LAST);
  assign init    = (st == ST_INIT) && !bist_abort;
  assign vin     = (st == ST_RUN) && !bist_abort;
  assign lfsr_en = vin && !last;
  assign misr_en = cap && !bist_abort;

  always_comb begin
    st_nxt = st;
    if (bist_abort) begin
      st_nxt = ST_IDLE;
    end else begin
      unique case (1'b1)
        st == ST_IDLE,
        st == ST_DONE:  if (bist_start) st_nxt = ST_INIT;
        st == ST_INIT:  st_nxt = ST_RUN;
        st == ST_RUN:
          if (last) st_nxt = (CUT_LATENCY == 0) ? ST_CMP : ST_FLUSH;
        st == ST_FLUSH: if (fl_cnt == FL_LAST) st_nxt = ST_CMP;
        st == ST_CMP:   st_nxt = ST_DONE;
        default:        st_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st            <= ST_IDLE;
      fl_cnt        <= '0;
      pattern_count <= '0;
      bist_busy     <= 1'b0;
      bist_done     <= 1'b0;
      bist_pass     <= 1'b0;
    end else begin
      st        <= st_nxt;
      fl_cnt    <= (st == ST_FLUSH) ? fl_cnt + 1'b1 : '0;
      bist_busy <= st_nxt inside {ST_INIT, ST_RUN, ST_FLUSH, ST_CMP};
      bist_done <= (st_nxt == ST_DONE);
      if (init) begin
        pattern_count <= '0;
      end else if (vin) begin
        pattern_count <= pattern_count + 1'b1;
      end
      if (bist_abort || st_nxt == ST_INIT) begin
        bist_pass <= 1'b0;
      end else if (st == ST_CMP) begin
        bist_pass <= (signature == GOLDEN_SIG);
      end
    end
  end

  // Valid bits travel alongside the pattern so the MISR only
  // samples responses that belong to issued stimuli.
  if (CUT_LATENCY == 0) begin : g_nolat
    assign cap = vin;
  end else begin : g_lat
    logic [CUT_LATENCY-1:0] vq;
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        vq <= '0;
      end else if (bist_abort) begin
        vq <= '0;
      end else begin
        vq <= (vq << 1) | CUT_LATENCY'(vin);
      end
    end
    assign cap = vq[CUT_LATENCY-1];
  end

  bist_shift_reg #(
    .WIDTH (WIDTH),
    .TAPS  (LFSR_TAPS),
    .MODE  (MODE_LFSR)
  ) u_lfsr (
    .clk      (clk),
    .rstn     (rstn),
    .load     (init),
    .load_val (SEED),
    .enable   (lfsr_en),
    .xor_in   ('0),
    .q        (cut_stim)
  );

  bist_shift_reg #(
    .WIDTH (WIDTH),
    .TAPS  (MISR_TAPS),
    .MODE  (MODE_MISR)
  ) u_misr (
    .clk      (clk),
    .rstn     (rstn),
    .load     (init),
    .load_val ('0),
    .enable   (misr_en),
    .xor_in   (cut_resp),
    .q        (signature)
  );

endmodule

// File: tb/tb_bist_engine.sv
// Scoreboard bench for bist_engine: several configurations run
// sessions against a high-level signature model.
module tb_bist_engine;

  localparam int N4 = 30;
  localparam int NP = 50;
  localparam int LP = 2;
  localparam int NZ = 20;

  // Spec-level model: fold every applied pattern's response into the
  // signature. mode 0 = loopback, 1 = bit0 stuck at 1, 2 = response 0.
  function automatic logic [31:0] ref_sig(
    int w, int n, logic [31:0] lt, logic [31:0] mt,
    logic [31:0] sd, int mode);
    logic [31:0] m, p, s, r;
    m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    p = sd & m;
    if (p == 0) p = 32'd1;
    s = 32'd0;
    for (int k = 0; k < n; k++) begin
      r = (mode == 0) ? p : (mode == 1) ? (p | 32'd1) : 32'd0;
      s = (((s << 1) | 32'(^(s & mt))) ^ r) & m;
      p = ((p << 1) | 32'(^(p & lt))) & m;
    end
    return s;
  endfunction

  localparam logic [7:0] G_P = 8'(ref_sig(8, NP, 32'hB8, 32'h8E, 32'h5A, 0));
  localparam logic [7:0] G_Z = 8'(ref_sig(8, NZ, 32'hB8, 32'hB8, 32'h0, 0));

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic st4 = 0, stp = 0, stn = 0, stf = 0, stz = 0, abp = 0;
  logic [3:0]  stim4, sig4;
  logic [7:0]  stimp, sigp, stimn, sign, stimf, sigf, stimz, sigz;
  logic [7:0]  respp, respn, respf, respz;
  logic [7:0]  dp1, dp2, dn1, dn2, df1, df2;
  logic [15:0] cnt4, cntp, cntn, cntf, cntz;
  logic [4:0]  busy_v, done_v, pass_v;
  logic [31:0] sig_v [5];

  always @(posedge clk) begin
    dp1 <= stimp; dp2 <= dp1;
    dn1 <= stimn; dn2 <= dn1;
    df1 <= stimf; df2 <= df1;
  end
  assign respp = dp2;
  assign respn = dn2;
  assign respf = df2 | 8'h01;
  assign respz = stimz;

  bist_engine #(.WIDTH(4), .NUM_PATTERNS(N4), .CUT_LATENCY(1),
    .LFSR_TAPS(4'b1001), .MISR_TAPS(4'b1001), .LFSR_SEED(4'd1),
    .GOLDEN_SIG(4'd0)) u_d4 (
    .clk(clk), .rstn(rstn), .bist_start(st4), .bist_abort(1'b0),
    .cut_stim(stim4), .cut_resp(4'd0), .bist_busy(busy_v[0]),
    .bist_done(done_v[0]), .bist_pass(pass_v[0]),
    .pattern_count(cnt4), .signature(sig4));

  bist_engine #(.WIDTH(8), .NUM_PATTERNS(NP), .CUT_LATENCY(LP),
    .LFSR_TAPS(8'hB8), .MISR_TAPS(8'h8E), .LFSR_SEED(8'h5A),
    .GOLDEN_SIG(G_P)) u_dp (
    .clk(clk), .rstn(rstn), .bist_start(stp), .bist_abort(abp),
    .cut_stim(stimp), .cut_resp(respp), .bist_busy(busy_v[1]),
    .bist_done(done_v[1]), .bist_pass(pass_v[1]),
    .pattern_count(cntp), .signature(sigp));

  bist_engine #(.WIDTH(8), .NUM_PATTERNS(NP), .CUT_LATENCY(LP),
    .LFSR_TAPS(8'hB8), .MISR_TAPS(8'h8E), .LFSR_SEED(8'h5A),
    .GOLDEN_SIG(G_P ^ 8'h01)) u_dn (
    .clk(clk), .rstn(rstn), .bist_start(stn), .bist_abort(1'b0),
    .cut_stim(stimn), .cut_resp(respn), .bist_busy(busy_v[2]),
    .bist_done(done_v[2]), .bist_pass(pass_v[2]),
    .pattern_count(cntn), .signature(sign));

  bist_engine #(.WIDTH(8), .NUM_PATTERNS(NP), .CUT_LATENCY(LP),
    .LFSR_TAPS(8'hB8), .MISR_TAPS(8'h8E), .LFSR_SEED(8'h5A),
    .GOLDEN_SIG(G_P)) u_df (
    .clk(clk), .rstn(rstn), .bist_start(stf), .bist_abort(1'b0),
    .cut_stim(stimf), .cut_resp(respf), .bist_busy(busy_v[3]),
    .bist_done(done_v[3]), .bist_pass(pass_v[3]),
    .pattern_count(cntf), .signature(sigf));

  bist_engine #(.WIDTH(8), .NUM_PATTERNS(NZ), .CUT_LATENCY(0),
    .LFSR_TAPS(8'hB8), .MISR_TAPS(8'hB8), .LFSR_SEED(8'h00),
    .GOLDEN_SIG(G_Z)) u_dz (
    .clk(clk), .rstn(rstn), .bist_start(stz), .bist_abort(1'b0),
    .cut_stim(stimz), .cut_resp(respz), .bist_busy(busy_v[4]),
    .bist_done(done_v[4]), .bist_pass(pass_v[4]),
    .pattern_count(cntz), .signature(sigz));

  assign sig_v[0] = 32'(sig4);
  assign sig_v[1] = 32'(sigp);
  assign sig_v[2] = 32'(sign);
  assign sig_v[3] = 32'(sigf);
  assign sig_v[4] = 32'(sigz);

  typedef struct {
    int          id;
    logic [31:0] sig;
    bit          pass;
    int          cyc;
  } exp_t;

  exp_t  sb[$];
  string nm [5] = '{"lfsr4", "loop", "gold_n", "fault", "zero"};

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, act, exp);
    end
  endtask

  task automatic push(int id, logic [31:0] s, bit p, int lat);
    exp_t e;
    e.id   = id;
    e.sig  = s;
    e.pass = p;
    e.cyc  = cyc + 1 + lat;
    sb.push_back(e);
  endtask

  task automatic pop(int id);
    int idx;
    idx = -1;
    foreach (sb[j]) if (idx < 0 && sb[j].id == id) idx = j;
    if (idx < 0) begin
      checks++;
      failures++;
      $display("FAIL %s_unexpected_done actual=1 required=0", nm[id]);
    end else begin
      chk($sformatf("%s_sig", nm[id]), sig_v[id], sb[idx].sig);
      chk($sformatf("%s_pass", nm[id]), 32'(pass_v[id]), 32'(sb[idx].pass));
      chk($sformatf("%s_done_cyc", nm[id]), cyc, sb[idx].cyc);
      sb.delete(idx);
    end
  endtask

  logic [4:0] done_q = '0;
  always @(negedge clk) begin
    for (int i = 0; i < 5; i++) if (done_v[i] && !done_q[i]) pop(i);
    done_q = done_v;
  end

  logic [3:0] seq [N4];
  logic [3:0] e4;
  logic [31:0] sig_f;
  int nd;
  bit dup;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_stim", stimp, 0);
    chk("rst_sig", sigp, 0);
    chk("rst_cnt", cntp, 0);
    chk("rst_busy", busy_v[1], 0);
    chk("rst_done", done_v[1], 0);
    chk("rst_pass", pass_v[1], 0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // all configurations in one session
    sig_f = ref_sig(8, NP, 32'hB8, 32'h8E, 32'h5A, 1);
    {st4, stp, stn, stf, stz} = 5'h1F;
    push(0, ref_sig(4, N4, 32'h9, 32'h9, 32'h1, 2), 1, N4 + 3);
    push(1, 32'(G_P), 1, NP + LP + 2);
    push(2, 32'(G_P), 0, NP + LP + 2);
    push(3, sig_f, sig_f == 32'(G_P), NP + LP + 2);
    push(4, 32'(G_Z), 1, NZ + 2);
    @(negedge clk);
    {st4, stp, stn, stf, stz} = 5'h00;
    chk("init_busy", busy_v[1], 1);
    for (int k = 1; k <= N4; k++) begin
      @(negedge clk);
      seq[k-1] = stim4;
      if (k == 1) chk("zero_seed_first", stimz, 1);
    end
    e4 = 4'd1;
    for (int i = 0; i < N4; i++) begin
      chk($sformatf("lfsr4_seq%0d", i), seq[i], e4);
      e4 = {e4[2:0], e4[3] ^ e4[0]};
    end
    nd = 0;
    for (int i = 0; i < 15; i++) begin
      dup = 0;
      for (int j = 0; j < i; j++) if (seq[j] == seq[i]) dup = 1;
      if (!dup && seq[i] != 4'd0) nd++;
    end
    chk("lfsr4_distinct15", nd, 15);
    repeat (30) @(negedge clk);
    chk("done_cnt", cntp, NP);
    chk("done_busy", busy_v[1], 0);

    // abort in RUN cycle 10
    stp = 1;
    @(negedge clk);
    stp = 0;
    repeat (10) @(negedge clk);
    chk("abort_pre_cnt", cntp, 9);
    abp = 1;
    @(negedge clk);
    abp = 0;
    chk("abort_busy", busy_v[1], 0);
    chk("abort_done", done_v[1], 0);
    chk("abort_pass", pass_v[1], 0);
    chk("abort_cnt", cntp, 9);
    repeat (3) @(negedge clk);
    chk("abort_cnt_frozen", cntp, 9);
    chk("abort_idle_busy", busy_v[1], 0);

    // clean rerun after abort
    stp = 1;
    push(1, 32'(G_P), 1, NP + LP + 2);
    @(negedge clk);
    stp = 0;
    repeat (60) @(negedge clk);

    // start while busy is ignored
    stp = 1;
    push(1, 32'(G_P), 1, NP + LP + 2);
    @(negedge clk);
    stp = 0;
    repeat (5) @(negedge clk);
    chk("busy_start_cnt4", cntp, 4);
    stp = 1;
    @(negedge clk);
    stp = 0;
    chk("busy_start_cnt5", cntp, 5);
    @(negedge clk);
    chk("busy_start_cnt6", cntp, 6);
    chk("busy_start_busy", busy_v[1], 1);
    repeat (60) @(negedge clk);

    // reset in FLUSH
    stp = 1;
    @(negedge clk);
    stp = 0;
    repeat (NP + 1) @(negedge clk);
    chk("flush_busy", busy_v[1], 1);
    chk("flush_cnt", cntp, NP);
    #2 rstn = 1'b0;
    #1;
    chk("arst_stim", stimp, 0);
    chk("arst_sig", sigp, 0);
    chk("arst_cnt", cntp, 0);
    chk("arst_busy", busy_v[1], 0);
    chk("arst_done", done_v[1], 0);
    chk("arst_pass", pass_v[1], 0);
    chk("arst_other_done", done_v[2], 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // recovery after reset
    stz = 1;
    push(4, 32'(G_Z), 1, NZ + 2);
    @(negedge clk);
    stz = 0;
    repeat (30) @(negedge clk);

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bist_engine.md
# bist_engine

Self-contained, parametrised logic-BIST engine that runs a complete test session without a testbench driving patterns. It generates a configurable number of pseudo-random stimuli, drives them into an external circuit-under-test (CUT), and compacts the CUT responses, accounting for the CUT's pipeline latency. It then compares the final signature against a golden value and reports pass/fail. It succeeds the fixed-width LFSR/MISR wrapper: it adds a session FSM, a pattern counter, latency alignment, abort, and programmable polynomials and seed.

## Interface
- WIDTH, 8, stimulus/response/signature width (2..32)
- NUM_PATTERNS, 255, patterns applied per session (1..2^16-1)
- CUT_LATENCY, 1, cycles from `cut_stim` to matching `cut_resp` (0..8)
- LFSR_TAPS, 8'hB8, LFSR feedback mask, WIDTH bits
- MISR_TAPS, 8'hB8, MISR feedback mask, WIDTH bits
- LFSR_SEED, 1, LFSR load value; 0 is replaced by 1
- GOLDEN_SIG, 0, expected final signature
- clk  input  1  clock; all state updates on rising edge
- rstn  input  1  asynchronous, active-low reset
- bist_start  input  1  single-cycle request to start a session (honoured in IDLE and DONE)
- bist_abort  input  1  terminate the session and return to IDLE
- cut_stim  output  WIDTH  pattern driven to the CUT
- cut_resp  input  WIDTH  CUT response
- bist_busy  output  1  high in INIT, RUN, FLUSH and COMPARE
- bist_done  output  1  high in DONE
- bist_pass  output  1  compare result; valid only while `bist_done` is high
- pattern_count  output  16  patterns issued in the current session
- signature  output  WIDTH  live MISR contents

## Operation
- **FSM states:** IDLE, INIT, RUN, FLUSH, COMPARE, DONE.
- **IDLE → INIT** on `bist_start`.
- **INIT (1 cycle):**
  - LFSR loads LFSR_SEED, or 1 if LFSR_SEED is 0.
  - MISR clears to 0.
  - `pattern_count` clears to 0.
- **RUN:**
  - Each cycle, `cut_stim` = LFSR state, and a valid bit enters the CUT_LATENCY-deep valid pipe.
  - The LFSR advances and `pattern_count` increments.
  - After the NUM_PATTERNS-th pattern is issued, go to FLUSH.
- **FLUSH:**
  - Lasts CUT_LATENCY cycles; with CUT_LATENCY = 0 it is skipped.
  - `cut_stim` holds its last value and no new valid bits enter the pipe.
- **MISR capture:** the MISR updates only when the pipe output bit is valid. With CUT_LATENCY = 0 it captures in the same cycle as the stimulus.
- **COMPARE (1 cycle):** registers `bist_pass` = (signature == GOLDEN_SIG).
- **DONE:** holds `bist_pass` and `signature`. `bist_start` → INIT.
- **LFSR:** Fibonacci, next = {p[WIDTH-2:0], ^(p & LFSR_TAPS)}.
- **MISR:** next = {s[WIDTH-2:0], ^(s & MISR_TAPS)} ^ cut_resp.
- **`bist_abort`:**
  - From any state, the next state is IDLE and the valid pipe clears.
  - `bist_pass` and `bist_done` go to 0.
  - `signature` and `pattern_count` freeze.
  - Abort has priority over start in the same cycle.
- **Start while busy:** ignored.

## Timing
- **Reset values:**
  - FSM = IDLE.
  - `cut_stim` = 0; LFSR = 0 until INIT.
  - `signature` = 0, `pattern_count` = 0.
  - `bist_busy`, `bist_done`, `bist_pass` = 0.
  - Valid pipe cleared.
- **Latency:** from the `bist_start` edge, `bist_done` rises after 1 + NUM_PATTERNS + CUT_LATENCY + 1 cycles.
- **First pattern:** appears on `cut_stim` the cycle after INIT.
- **Outputs:** all are registered; there is no combinational path from inputs to outputs.
- **`rstn` mid-session:** asynchronous return to reset values; no partial result is reported.

## Structure
- Shared package `bist_pkg`:
  - state enum (IDLE..DONE),
  - counter width constant (16),
  - the default tap masks.
- One sub-module, `bist_shift_reg`, instantiated twice:
  - parameters WIDTH, TAPS, MODE (LFSR/MISR);
  - inputs load, load_val, enable, xor_in.
- FSM, counter and valid pipe live in `bist_engine`.

## Test plan
- **LFSR sequence:**
  - Stimulus: WIDTH=4, LFSR_TAPS=4'b1001, seed 1, `cut_resp` tied 0.
  - Required: `cut_stim` runs 0001, 0011, 0111, 1111, 1110, …
  - Required: period is exactly 15 with no 0000.
- **Loopback pass/fail:**
  - Stimulus: CUT modelled as a CUT_LATENCY-cycle delay of `cut_stim`, CUT_LATENCY=2.
  - Required: `bist_done` rises 1+NUM_PATTERNS+2+1 cycles after start.
  - Required: `bist_pass`=1 when GOLDEN_SIG equals the model-computed signature; rerun with GOLDEN_SIG^1 → `bist_pass`=0.
- **Fault detection:** the same loopback with bit 0 of `cut_resp` stuck at 1 → signature ≠ golden and `bist_pass`=0.
- **Zero latency and zero seed:** CUT_LATENCY=0 and LFSR_SEED=0 → FLUSH skipped, first stimulus is 1, result identical to the reference model.
- **Abort:** `bist_abort` in cycle 10 of RUN → IDLE next cycle, `bist_busy`=0, `bist_done`=0, `pattern_count` frozen at its value (9 or 10 per model). A new `bist_start` then completes normally.
- **Reset and start while busy:** `rstn` low during FLUSH → all outputs at reset values asynchronously. `bist_start` pulsed in RUN → no restart and `pattern_count` keeps incrementing.
